// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types
// for the in-order front-end pipeline
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO
// with flush, used for fetch buffering
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Pointers and occupancy; a flush discards everything, including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem req/gnt/rvalid
// port, tagged instruction buffer, redirect flush
module instruction_fetch_unit #(
    parameter int unsigned     XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_err
);

    import riscv_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = ILEN + XLEN;

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nx;
    logic [CW-1:0]   discard;
    logic            credit;
    logic            fire;
    logic            rv_take;
    logic            rv_keep;
    logic            pop;

    logic [EW-1:0]   head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_full;
    logic            pcq_empty;
    logic            unused_ok;

    assign credit = ({1'b0, outstanding} + {1'b0, fifo_count})
                    < (CW+1)'(FIFO_DEPTH);

    assign imem_req  = (state == S_RUN) && credit && !redirect_valid;
    assign imem_addr = pc;

    assign fire    = imem_req && imem_gnt;
    assign rv_take = imem_rvalid && (outstanding != '0);
    assign rv_keep = rv_take && (discard == '0);

    assign outstanding_nx = outstanding + CW'(fire) - CW'(rv_take);

    assign if_valid = !fifo_empty;
    assign pop      = if_valid && if_ready;
    assign if_inst  = fifo_empty ? '0 : head[EW-1 -: ILEN];
    assign if_pc    = fifo_empty ? '0 : head[XLEN-1:0];

    assign unused_ok = ^{fifo_full, pcq_full, pcq_count, pcq_empty};

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (rv_keep),
        .flush (redirect_valid),
        .wdata (pc),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rv_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rdata, pcq_head}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch control: PC, in-flight and discard counts, FSM, misalign pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            outstanding  <= '0;
            discard      <= '0;
            misalign_err <= 1'b0;
        end else begin
            outstanding  <= outstanding_nx;
            misalign_err <= redirect_valid
                            && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc      <= {redirect_pc[XLEN-1:2], 2'b00};
                discard <= outstanding_nx;
                if (outstanding_nx != '0 || state == S_DRAIN)
                    state <= S_DRAIN;
                else
                    state <= S_RUN;
            end else begin
                if (fire)
                    pc <= pc + XLEN'(4);
                if (rv_take && discard != '0)
                    discard <= discard - 1'b1;
                unique case (state)
                    S_BOOT:
                        state <= S_RUN;
                    S_DRAIN:
                        if (discard == '0
                            || (rv_take && discard == CW'(1)))
                            state <= S_RUN;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: in-order memory responder,
// scoreboard of delivered instructions, directed checks
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        misalign_err;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b1;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_redir = 1'b0;
    logic [31:0] w_rpc = '0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_mis;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_en = 1'b1;
    req_t        mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] wrap_addr_log[$];
    logic [31:0] wrap_pc_log[$];
    logic        w_pend = 1'b0;
    logic [31:0] w_paddr = '0;

    instruction_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_gnt       (w_gnt),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_redir),
        .redirect_pc    (w_rpc),
        .if_valid       (w_valid),
        .if_ready       (w_ready),
        .if_inst        (w_inst),
        .if_pc          (w_pc),
        .misalign_err   (w_mis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_2203 : (a ^ 32'h5A00_0013);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req},     32'h0);
        chk({tag, "_addr"},  imem_addr,             32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid},     32'h0);
        chk({tag, "_inst"},  if_inst,               32'h0);
        chk({tag, "_pc"},    if_pc,                 32'h0);
        chk({tag, "_mis"},   {31'b0, misalign_err}, 32'h0);
    endtask

    // Memory: in-order responses lat cycles after grant; pushes expected output.
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        imem_gnt = gnt_en;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #2;
        if (!rst_n) begin
            mem_q.delete();
        end else begin
            if (imem_rvalid) begin
                r = mem_q.pop_front();
                if (!r.stale && !redirect_valid) begin
                    e.pc   = r.addr;
                    e.inst = mem_word(r.addr);
                    exp_q.push_back(e);
                end
            end
            if (redirect_valid)
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            if (imem_req && imem_gnt) begin
                r.addr  = imem_addr;
                r.due   = cyc + lat;
                r.stale = 1'b0;
                mem_q.push_back(r);
            end
        end
        cyc++;
    end

    // Monitor: compare every accepted instruction with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (if_valid && if_ready) begin
                pop_log.push_back(if_pc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got pc %h, expected none",
                             if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_inst", if_inst, e.inst);
                end
            end
            if (redirect_valid)
                exp_q.delete();
        end
    end

    // Wrap instance: grant always, respond one cycle later.
    always @(negedge clk) begin
        w_rvalid = w_pend;
        w_rdata  = mem_word(w_paddr);
        #2;
        if (!rst_n) begin
            w_pend = 1'b0;
        end else begin
            w_pend  = w_req;
            w_paddr = w_addr;
            if (w_req)
                wrap_addr_log.push_back(w_addr);
            if (w_valid)
                wrap_pc_log.push_back(w_pc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        hit = 1'b0;

        // reset values and plain streaming
        step(3);
        #3 chk_reset("por");
        step(1);
        rst_n = 1'b1;
        step(20);
        #3;
        chk("t1_pc0", pop_log[0], 32'h0);
        chk("t1_pc1", pop_log[1], 32'h4);
        chk("t1_pc2", pop_log[2], 32'h8);
        chk("t1_pc3", pop_log[3], 32'hC);
        chk("t1_pc4", pop_log[4], 32'h10);

        // asynchronous reset mid-stream, then decoder stall
        step(1);
        rst_n    = 1'b0;
        if_ready = 1'b0;
        #3 chk_reset("async");
        step(2);
        rst_n = 1'b1;
        pop_log.delete();
        step(4);
        #3;
        chk("t2_valid", {31'b0, if_valid}, 32'h1);
        chk("t2_pc_a", if_pc, 32'h0);
        chk("t2_inst_a", if_inst, 32'h0000_2203);
        chk("t2_req_a", {31'b0, imem_req}, 32'h0);
        step(2);
        #3;
        chk("t2_pc_b", if_pc, 32'h0);
        chk("t2_inst_b", if_inst, 32'h0000_2203);
        chk("t2_req_b", {31'b0, imem_req}, 32'h0);
        step(1);
        if_ready = 1'b1;
        step(12);
        #3;
        chk("t2_pc0", pop_log[0], 32'h0);
        chk("t2_pc1", pop_log[1], 32'h4);
        chk("t2_pc2", pop_log[2], 32'h8);
        chk("t2_pc3", pop_log[3], 32'hC);

        // redirect with two fetches in flight
        step(1);
        rst_n = 1'b0;
        step(2);
        lat   = 3;
        rst_n = 1'b1;
        pop_log.delete();
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #3 chk("t3_req_redir", {31'b0, imem_req}, 32'h0);
        step(1);
        redirect_valid = 1'b0;
        #3;
        chk("t3_drain_req0", {31'b0, imem_req}, 32'h0);
        chk("t3_late_rv0", {31'b0, imem_rvalid}, 32'h1);
        step(1);
        #3;
        chk("t3_drain_req1", {31'b0, imem_req}, 32'h0);
        chk("t3_late_rv1", {31'b0, imem_rvalid}, 32'h1);
        step(1);
        #3;
        chk("t3_run_req", {31'b0, imem_req}, 32'h1);
        chk("t3_run_addr", imem_addr, 32'h100);
        step(15);
        #3;
        chk("t3_pc0", pop_log[0], 32'h100);
        chk("t3_pc1", pop_log[1], 32'h104);

        // misaligned redirect
        lat = 1;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step(1);
        redirect_valid = 1'b0;
        pop_log.delete();
        #3;
        chk("t4_mis_hi", {31'b0, misalign_err}, 32'h1);
        chk("t4_addr", imem_addr, 32'h100);
        step(1);
        #3 chk("t4_mis_lo", {31'b0, misalign_err}, 32'h0);
        step(12);
        #3 chk("t4_pc0", pop_log[0], 32'h100);

        // redirect in the same cycle as gnt and rvalid
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (imem_rvalid) begin
                hit            = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
            end
        end
        chk("t6_rvalid_seen", {31'b0, hit}, 32'h1);
        #2;
        chk("t6_gnt", {31'b0, imem_gnt}, 32'h1);
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        step(1);
        redirect_valid = 1'b0;
        pop_log.delete();
        #3;
        chk("t6_flushed", {31'b0, if_valid}, 32'h0);
        chk("t6_addr", imem_addr, 32'h200);
        step(12);
        #3;
        chk("t6_pc0", pop_log[0], 32'h200);
        chk("t6_pc1", pop_log[1], 32'h204);

        // stop granting and let everything drain
        gnt_en = 1'b0;
        step(10);
        #3;
        chk("end_sb_left", exp_q.size(), 32'h0);
        chk("end_valid", {31'b0, if_valid}, 32'h0);

        // reset PC near the top of the address space
        chk("t5_addr0", wrap_addr_log[0], 32'hFFFF_FFF8);
        chk("t5_addr1", wrap_addr_log[1], 32'hFFFF_FFFC);
        chk("t5_addr2", wrap_addr_log[2], 32'h0000_0000);
        chk("t5_pc0", wrap_pc_log[0], 32'hFFFF_FFF8);
        chk("t5_pc1", wrap_pc_log[1], 32'hFFFF_FFFC);
        chk("t5_pc2", wrap_pc_log[2], 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
